apuracao_votos: RTL and testbench
=================================

# apuracao_votos

Day-phase vote tally for the PoliLobinho game. Sits directly downstream of the player-selection converter and beside the turn counter. Each living player casts one vote, either for a living player or for skip (pular). At the end of the round the block reports the single eliminated player, or no elimination on a tie or an empty result. Its pulse `pronto` is consumed by the game controller to trigger the elimination update.

## Interface
Parameters:
- `N_JOGADORES`, default 5: number of players; player IDs are 0..N_JOGADORES-1.
- `W_ID`, default 3: width of player IDs.
- `ID_PULAR`, default 5: ID code that means an abstention / skip vote.
- `ID_NENHUM`, default 7: ID code that means "no one eliminated".

Ports (one clock; reset is synchronous and active-high):
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; returns the block to OCIOSO.
- `iniciar`  in  1  pulse; clears all tallies and starts collection.
- `voto_valido`  in  1  pulse; a vote is presented this cycle.
- `jogador_votante`  in  W_ID  ID of the player casting the vote.
- `jogador_escolhido`  in  W_ID  target ID, or ID_PULAR.
- `vivos`  in  N_JOGADORES  living-player mask; sampled on every vote and during apuração.
- `fim_votacao`  in  1  pulse; closes collection and starts the count.
- `eliminado`  out  W_ID  result ID, or ID_NENHUM.
- `empate`  out  1  the top count is tied.
- `pronto`  out  1  one-cycle pulse; the result is valid from this cycle.
- `todos_votaram`  out  1  registered; every living player has voted.
- `db_estado`  out  2  current FSM state code.

## Operation
FSM states and encodings: OCIOSO=0, COLETA=1, APURA=2, FIM=3.

- **OCIOSO**
  - Holds the last result.
  - `iniciar` → COLETA.
  - Votes and `fim_votacao` are ignored.
- **COLETA**
  - A vote is accepted only when all of the following hold:
    - `voto_valido`=1.
    - The voter is < N_JOGADORES.
    - `vivos[voter]`=1.
    - `votou[voter]`=0.
  - On acceptance, set `votou[voter]`=1. Then:
    - Target is a living player → increment `cont[target]`.
    - Target is ID_PULAR → increment `abstencoes`.
    - Any other target (dead player, out of range) → the voter is marked as voted and nothing is counted.
  - Rejected votes change nothing.
  - `fim_votacao` → APURA, index i=0, max=0, arg=ID_NENHUM, emp=0.
- **APURA**
  - One candidate per cycle, i = 0..N_JOGADORES-1, using only living candidates:
    - `cont[i]` > max → max=cont[i], arg=i, emp=0.
    - `cont[i]` == max and max > 0 → emp=1.
  - After i=N_JOGADORES-1 → FIM.
- **FIM** (lasts one cycle)
  - `eliminado` is:
    - `arg`, when max > 0, emp=0 and max > `abstencoes`;
    - `ID_NENHUM` otherwise.
  - `empate` = emp.
  - `pronto` = 1.
  - Next state → OCIOSO.

Counters:
- Each `cont[i]` and `abstencoes` is W_ID bits wide and saturates at N_JOGADORES.
- Because of the duplicate-vote rule, saturation never triggers in legal use.

`todos_votaram`:
- Defined as (`votou` & `vivos`) == `vivos`, registered.
- Forced to 0 outside COLETA.

## Timing
Reset values: `eliminado`=ID_NENHUM, `empate`=0, `pronto`=0, `todos_votaram`=0, `db_estado`=0, all counts and `votou` = 0.

Latency:
- Accepted vote: the count is updated at the edge that samples it.
- `fim_votacao` sampled at edge 0:
  - APURA covers edges 1..N_JOGADORES.
  - FIM is registered at edge N_JOGADORES+1.
  - `pronto` is high for exactly one cycle after that edge, so latency is N_JOGADORES+1 edges (6 at default).

Priorities and boundary cases:
- `reset` takes priority over everything.
- `iniciar` in any state clears tallies, `votou` and `pronto`, then → COLETA. This aborts an APURA in progress with no `pronto`.
- `voto_valido` and `fim_votacao` in the same cycle: the vote is counted, then the FSM moves to APURA.
- `fim_votacao` with zero votes → `eliminado`=ID_NENHUM, `empate`=0.
- All living players skip → ID_NENHUM.
- Outputs hold through OCIOSO until the next `iniciar` or `reset`.

## Structure
- Shared package `lobinho_pkg` holds:
  - the player count and ID width;
  - `ID_PULAR` and `ID_NENHUM`;
  - the FSM state encoding, shared with `estado7seg` debug decoding.
- One natural sub-module, `contador_voto`: a per-player saturating counter with clear and enable, instantiated N_JOGADORES+1 times (one per player plus `abstencoes`).
- The FSM, `votou` mask and argmax scan stay in the top module.

## Test plan
- **Simple majority.** Players 0–4 alive. Votes: 0→2, 1→2, 2→3, 3→2, 4→pular; then `fim` → after 6 edges `pronto`=1, `eliminado`=2, `empate`=0.
- **Tie.** Votes: 0→1, 1→0, 2→1, 3→0, 4→pular → `eliminado`=7, `empate`=1.
- **Filtering.** Set `vivos`=5'b10111 (player 3 dead). Player 3 votes →4, player 0 votes twice (→4, then →1), player 1 votes →3 (dead target); `fim` → `cont[4]`=1, the vote for dead player 3 is not counted, `eliminado`=4, `todos_votaram`=0 before `fim`.
- **Abstentions dominate.** Votes: 0→2, 1→pular, 2→pular, 3→pular, 4→pular → `eliminado`=7, `empate`=0.
- **Simultaneous events and abort.**
  - Last vote 4→1 issued in the same cycle as `fim`, with the earlier votes 0→1 and 2→3 → the last vote is included and `eliminado`=1.
  - `iniciar` during APURA → no `pronto`, counts return to 0, state is COLETA.
- **Mid-operation reset.** `reset` during COLETA after 3 votes → next cycle all outputs are at their reset values and the state is OCIOSO.

Source files
------------

// File: rtl/lobinho_pkg.sv
// rtl/lobinho_pkg.sv - shared PoliLobinho constants and FSM state encoding
package lobinho_pkg;

    localparam int DEF_N_JOGADORES = 5;
    localparam int DEF_W_ID        = 3;
    localparam int DEF_ID_PULAR    = 5;
    localparam int DEF_ID_NENHUM   = 7;

    // Also decoded by estado7seg for the debug display.
    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        COLETA = 2'd1,
        APURA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

endpackage

// File: rtl/contador_voto.sv
// rtl/contador_voto.sv - saturating vote counter with synchronous clear and enable
module contador_voto #(
    parameter int W   = 3,
    parameter int MAX = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         limpar,
    input  logic         habilita,
    output logic [W-1:0] contagem
);

    logic [W-1:0] contagem_q;
    logic [W-1:0] contagem_d;

    always_comb begin
        contagem_d = contagem_q;
        if (limpar) begin
            contagem_d = '0;
        end else if (habilita && (contagem_q < W'(MAX))) begin
            contagem_d = contagem_q + W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            contagem_q <= '0;
        end else begin
            contagem_q <= contagem_d;
        end
    end

    assign contagem = contagem_q;

endmodule

// File: rtl/apuracao_votos.sv
// rtl/apuracao_votos.sv - day-phase vote collection and argmax tally
module apuracao_votos
    import lobinho_pkg::*;
#(
    parameter int N_JOGADORES = DEF_N_JOGADORES,
    parameter int W_ID        = DEF_W_ID,
    parameter int ID_PULAR    = DEF_ID_PULAR,
    parameter int ID_NENHUM   = DEF_ID_NENHUM
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iniciar,
    input  logic                   voto_valido,
    input  logic [W_ID-1:0]        jogador_votante,
    input  logic [W_ID-1:0]        jogador_escolhido,
    input  logic [N_JOGADORES-1:0] vivos,
    input  logic                   fim_votacao,
    output logic [W_ID-1:0]        eliminado,
    output logic                   empate,
    output logic                   pronto,
    output logic                   todos_votaram,
    output logic [1:0]             db_estado
);

    localparam logic [W_ID-1:0]        PULAR  = W_ID'(ID_PULAR);
    localparam logic [W_ID-1:0]        NENHUM = W_ID'(ID_NENHUM);
    localparam logic [W_ID-1:0]        ULTIMO = W_ID'(N_JOGADORES - 1);
    localparam logic [N_JOGADORES-1:0] UM     = N_JOGADORES'(1);

    estado_t                state_q, state_d;
    logic [N_JOGADORES-1:0] votou_q, votou_d;
    logic [W_ID-1:0]        idx_q, idx_d;
    logic [W_ID-1:0]        max_q, max_d;
    logic [W_ID-1:0]        arg_q, arg_d;
    logic                   emp_q, emp_d;
    logic [W_ID-1:0]        eliminado_q, eliminado_d;
    logic                   empate_q, empate_d;
    logic                   pronto_q, pronto_d;
    logic                   todos_q, todos_d;

    logic [W_ID-1:0]        cont [N_JOGADORES];
    logic [W_ID-1:0]        abstencoes;
    logic [N_JOGADORES-1:0] cont_en;
    logic                   abst_en;
    logic                   limpar;
    logic                   aceita;
    logic [N_JOGADORES-1:0] votante_oh;
    logic [N_JOGADORES-1:0] alvo_oh;
    logic [W_ID-1:0]        cand;
    logic                   cand_vivo;

    // Out-of-range IDs shift the one-hot to zero, so they match no player.
    assign votante_oh = UM << jogador_votante;
    assign alvo_oh    = UM << jogador_escolhido;
    assign cont_en    = aceita ? (alvo_oh & vivos) : '0;
    assign abst_en    = aceita && (jogador_escolhido == PULAR);

    for (genvar g = 0; g < N_JOGADORES; g++) begin : g_cont
        contador_voto #(.W(W_ID), .MAX(N_JOGADORES)) u_cont (
            .clock    (clock),
            .reset    (reset),
            .limpar   (limpar),
            .habilita (cont_en[g]),
            .contagem (cont[g])
        );
    end

    contador_voto #(.W(W_ID), .MAX(N_JOGADORES)) u_abst (
        .clock    (clock),
        .reset    (reset),
        .limpar   (limpar),
        .habilita (abst_en),
        .contagem (abstencoes)
    );

    always_comb begin
        cand      = '0;
        cand_vivo = 1'b0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            if (idx_q == W_ID'(i)) begin
                cand      = cont[i];
                cand_vivo = vivos[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        votou_d     = votou_q;
        idx_d       = idx_q;
        max_d       = max_q;
        arg_d       = arg_q;
        emp_d       = emp_q;
        eliminado_d = eliminado_q;
        empate_d    = empate_q;
        pronto_d    = 1'b0;
        limpar      = 1'b0;
        aceita      = 1'b0;

        if (iniciar) begin
            limpar  = 1'b1;
            votou_d = '0;
            state_d = COLETA;
        end else begin
            case (state_q)
                COLETA: begin
                    aceita = voto_valido && |(votante_oh & vivos & ~votou_q);
                    if (aceita) begin
                        votou_d = votou_q | votante_oh;
                    end
                    if (fim_votacao) begin
                        state_d = APURA;
                        idx_d   = '0;
                        max_d   = '0;
                        arg_d   = NENHUM;
                        emp_d   = 1'b0;
                    end
                end
                APURA: begin
                    if (cand_vivo) begin
                        if (cand > max_q) begin
                            max_d = cand;
                            arg_d = idx_q;
                            emp_d = 1'b0;
                        end else if ((cand == max_q) && (max_q != '0)) begin
                            emp_d = 1'b1;
                        end
                    end
                    if (idx_q == ULTIMO) begin
                        state_d = FIM;
                    end else begin
                        idx_d = idx_q + W_ID'(1);
                    end
                end
                FIM: begin
                    eliminado_d = ((max_q != '0) && !emp_q && (max_q > abstencoes)) ? arg_q : NENHUM;
                    empate_d    = emp_q;
                    pronto_d    = 1'b1;
                    state_d     = OCIOSO;
                end
                default: ;
            endcase
        end

        todos_d = (state_d == COLETA) && ((votou_d & vivos) == vivos);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= OCIOSO;
            votou_q     <= '0;
            idx_q       <= '0;
            max_q       <= '0;
            arg_q       <= NENHUM;
            emp_q       <= 1'b0;
            eliminado_q <= NENHUM;
            empate_q    <= 1'b0;
            pronto_q    <= 1'b0;
            todos_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            votou_q     <= votou_d;
            idx_q       <= idx_d;
            max_q       <= max_d;
            arg_q       <= arg_d;
            emp_q       <= emp_d;
            eliminado_q <= eliminado_d;
            empate_q    <= empate_d;
            pronto_q    <= pronto_d;
            todos_q     <= todos_d;
        end
    end

    assign eliminado     = eliminado_q;
    assign empate        = empate_q;
    assign pronto        = pronto_q;
    assign todos_votaram = todos_q;
    assign db_estado     = state_q;

endmodule

// File: tb/tb_apuracao_votos.sv
// tb/tb_apuracao_votos.sv - randomized self-checking bench for apuracao_votos
module tb_apuracao_votos;

    localparam int N = 5;

    logic         clock = 1'b0;
    logic         reset;
    logic         iniciar;
    logic         voto_valido;
    logic [2:0]   jogador_votante;
    logic [2:0]   jogador_escolhido;
    logic [N-1:0] vivos;
    logic         fim_votacao;
    logic [2:0]   eliminado;
    logic         empate;
    logic         pronto;
    logic         todos_votaram;
    logic [1:0]   db_estado;

    int checks = 0;
    int errors = 0;

    // Reference tallies: plain arrays of vote counts per player.
    int   cont_m [N];
    int   abst_m;
    bit   votou_m [N];
    bit   coletando;

    apuracao_votos dut (
        .clock             (clock),
        .reset             (reset),
        .iniciar           (iniciar),
        .voto_valido       (voto_valido),
        .jogador_votante   (jogador_votante),
        .jogador_escolhido (jogador_escolhido),
        .vivos             (vivos),
        .fim_votacao       (fim_votacao),
        .eliminado         (eliminado),
        .empate            (empate),
        .pronto            (pronto),
        .todos_votaram     (todos_votaram),
        .db_estado         (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            cont_m[i]  = 0;
            votou_m[i] = 1'b0;
        end
        abst_m = 0;
    endtask

    task automatic model_vote(input int v, input int t);
        if (coletando && v < N) begin
            if (vivos[v] && !votou_m[v]) begin
                votou_m[v] = 1'b1;
                if (t < N && vivos[t]) cont_m[t]++;
                else if (t == 5) abst_m++;
            end
        end
    endtask

    function automatic bit model_todos();
        bit ok = 1'b1;
        for (int i = 0; i < N; i++) if (vivos[i] && !votou_m[i]) ok = 1'b0;
        return ok;
    endfunction

    task automatic model_result(output int el, output int em);
        int mx = 0;
        int nmax = 0;
        int who = 7;
        for (int i = 0; i < N; i++) if (vivos[i] && cont_m[i] > mx) mx = cont_m[i];
        for (int i = 0; i < N; i++) begin
            if (vivos[i] && cont_m[i] == mx) begin
                nmax++;
                who = i;
            end
        end
        el = (mx > 0 && nmax == 1 && mx > abst_m) ? who : 7;
        em = (mx > 0 && nmax > 1) ? 1 : 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        coletando = 1'b0;
        model_clear();
    endtask

    task automatic start();
        iniciar = 1'b1;
        step();
        iniciar = 1'b0;
        coletando = 1'b1;
        model_clear();
    endtask

    task automatic vote(input int v, input int t, input bit chk_todos);
        voto_valido       = 1'b1;
        jogador_votante   = 3'(v);
        jogador_escolhido = 3'(t);
        step();
        voto_valido = 1'b0;
        model_vote(v, t);
        if (chk_todos) check("todos_votaram", 32'(todos_votaram), 32'(model_todos()));
    endtask

    task automatic finish_round(input bit with_vote, input int v, input int t);
        int el, em, lat;
        fim_votacao = 1'b1;
        if (with_vote) begin
            voto_valido       = 1'b1;
            jogador_votante   = 3'(v);
            jogador_escolhido = 3'(t);
        end
        step();
        fim_votacao = 1'b0;
        voto_valido = 1'b0;
        if (with_vote) model_vote(v, t);
        coletando = 1'b0;
        check("estado_apura", 32'(db_estado), 32'd2);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (pronto) begin
                lat = k;
                break;
            end
        end
        model_result(el, em);
        check("latencia_pronto", 32'(lat), 32'(N + 1));
        check("eliminado", 32'(eliminado), 32'(el));
        check("empate", 32'(empate), 32'(em));
        step();
        check("pronto_pulso", 32'(pronto), 32'd0);
        check("eliminado_mantido", 32'(eliminado), 32'(el));
        check("estado_ocioso", 32'(db_estado), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_eliminado"}, 32'(eliminado), 32'd7);
        check({tag, "_empate"}, 32'(empate), 32'd0);
        check({tag, "_pronto"}, 32'(pronto), 32'd0);
        check({tag, "_todos"}, 32'(todos_votaram), 32'd0);
        check({tag, "_estado"}, 32'(db_estado), 32'd0);
    endtask

    initial begin
        int npront;
        reset = 1'b1; iniciar = 1'b0; voto_valido = 1'b0; fim_votacao = 1'b0;
        jogador_votante = '0; jogador_escolhido = '0; vivos = 5'b11111;
        coletando = 1'b0;
        model_clear();
        step();
        do_reset();
        check_reset_outputs("reset");

        // Votes and fim while idle are ignored.
        vote(0, 1, 1'b0);
        fim_votacao = 1'b1; step(); fim_votacao = 1'b0;
        check("ocioso_ignora", 32'(db_estado), 32'd0);

        // Simple majority
        start();
        check("estado_coleta", 32'(db_estado), 32'd1);
        vote(0, 2, 1'b1); vote(1, 2, 1'b1); vote(2, 3, 1'b1); vote(3, 2, 1'b1); vote(4, 5, 1'b1);
        finish_round(1'b0, 0, 0);

        // Tie
        start();
        vote(0, 1, 1'b0); vote(1, 0, 1'b0); vote(2, 1, 1'b0); vote(3, 0, 1'b0); vote(4, 5, 1'b1);
        finish_round(1'b0, 0, 0);

        // Filtering with player 3 dead
        vivos = 5'b10111;
        start();
        vote(3, 4, 1'b1); vote(0, 4, 1'b1); vote(0, 1, 1'b1); vote(1, 3, 1'b1);
        check("todos_antes_fim", 32'(todos_votaram), 32'd0);
        finish_round(1'b0, 0, 0);
        vivos = 5'b11111;

        // Abstentions dominate
        start();
        vote(0, 2, 1'b0); vote(1, 5, 1'b0); vote(2, 5, 1'b0); vote(3, 5, 1'b0); vote(4, 5, 1'b1);
        finish_round(1'b0, 0, 0);

        // Zero votes
        start();
        finish_round(1'b0, 0, 0);

        // Last vote together with fim
        start();
        vote(0, 1, 1'b0); vote(2, 3, 1'b0);
        finish_round(1'b1, 4, 1);

        // Abort an apuracao in progress
        start();
        vote(0, 2, 1'b0); vote(1, 2, 1'b0);
        fim_votacao = 1'b1; step(); fim_votacao = 1'b0;
        step(); step();
        start();
        check("abort_estado", 32'(db_estado), 32'd1);
        npront = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (pronto) npront++;
        end
        check("abort_sem_pronto", 32'(npront), 32'd0);
        check("abort_estado_mantido", 32'(db_estado), 32'd1);
        finish_round(1'b0, 0, 0);

        // Reset mid-collection after a non-trivial result
        start();
        vote(0, 3, 1'b0); vote(1, 3, 1'b0);
        finish_round(1'b0, 0, 0);
        start();
        vote(0, 1, 1'b0); vote(1, 2, 1'b0); vote(2, 1, 1'b0);
        do_reset();
        check_reset_outputs("reset_meio");

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            int nv;
            vivos = 5'($urandom_range(0, 31));
            start();
            nv = $urandom_range(0, 12);
            for (int j = 0; j < nv; j++) begin
                vote($urandom_range(0, 7), $urandom_range(0, 7), 1'b1);
            end
            finish_round(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
